// File: rtl/cnn_window_feeder.sv
// Buffers one IMG_W x IMG_W frame, then streams every KxK window (one per cycle)
// to a CNN core and captures the class index the core reports back.
module cnn_window_feeder #(
    parameter int IMG_W = 28,
    parameter int K     = 5,
    parameter int OUT_W = IMG_W - K + 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             PIX_VALID,
    input  logic [7:0]       PIX_IN,
    output logic             PIX_READY,
    output logic             START,
    output logic [4:0]       X,
    output logic [4:0]       Y,
    output logic [K*K*8-1:0] IMGIN,
    input  logic             CNN_DONE,
    input  logic [3:0]       CNN_OUT,
    output logic             RESULT_VALID,
    output logic [3:0]       RESULT,
    output logic             BUSY
);

    localparam int NPIX = IMG_W * IMG_W;
    localparam int AW   = $clog2(NPIX);
    localparam logic [4:0] LAST_POS = 5'(OUT_W - 1);

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_KICK,
        ST_STREAM,
        ST_WAIT,
        ST_REPORT
    } state_e;

    state_e             state_q, state_d;
    logic [AW-1:0]      cnt_q, cnt_d;
    logic [4:0]         x_q, x_d, y_q, y_d;
    logic [K*K*8-1:0]   imgin_q, imgin_d, win_d;
    logic               start_q, start_d;
    logic               result_valid_q, result_valid_d;
    logic [3:0]         result_q, result_d;
    logic [AW-1:0]      rd_addr;
    logic [7:0]         img_mem [NPIX];

    logic pix_ready, busy, accept, last_pix, last_win, win_ld;

    assign accept   = PIX_VALID && pix_ready;
    assign last_pix = (cnt_q == AW'(NPIX - 1));
    assign last_win = (x_q == LAST_POS) && (y_q == LAST_POS);

    // NOTE: async reset applies to every flop here, with non-blocking
    // assignments so all state updates see the pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q        <= ST_LOAD;
            cnt_q          <= '0;
            x_q            <= '0;
            y_q            <= '0;
            imgin_q        <= '0;
            start_q        <= 1'b0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            x_q            <= x_d;
            y_q            <= y_d;
            imgin_q        <= imgin_d;
            start_q        <= start_d;
            result_valid_q <= result_valid_d;
            result_q       <= result_d;
        end
    end

    // NOTE: the image buffer is deliberately not reset; every frame rewrites
    // all of it before any window is read.
    always_ff @(posedge CLK) begin
        if (accept) img_mem[cnt_q] <= PIX_IN;
    end

    // NOTE: every variable gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD:   if (accept && last_pix) state_d = ST_KICK;
            ST_KICK:   state_d = ST_STREAM;
            ST_STREAM: if (last_win) state_d = ST_WAIT;
            ST_WAIT:   if (CNN_DONE) state_d = ST_REPORT;
            ST_REPORT: state_d = ST_LOAD;
            default:   state_d = ST_LOAD;
        endcase
    end

    always_comb begin
        pix_ready = (state_q == ST_LOAD);
        busy      = (state_q != ST_LOAD);
    end

    // Window position walk; (0,0) is presented in KICK and again on the first STREAM cycle.
    always_comb begin
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        win_ld   = 1'b0;
        result_d = result_q;
        unique case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    cnt_d = last_pix ? '0 : cnt_q + 1'b1;
                    if (last_pix) begin
                        x_d    = '0;
                        y_d    = '0;
                        win_ld = 1'b1;
                    end
                end
            end
            ST_KICK: begin
                x_d    = '0;
                y_d    = '0;
                win_ld = 1'b1;
            end
            ST_STREAM: begin
                if (!last_win) begin
                    win_ld = 1'b1;
                    if (y_q == LAST_POS) begin
                        y_d = '0;
                        x_d = x_q + 1'b1;
                    end else begin
                        y_d = y_q + 1'b1;
                    end
                end
            end
            ST_WAIT:   if (CNN_DONE) result_d = CNN_OUT;
            default:   ;
        endcase
        start_d        = (state_d == ST_KICK);
        result_valid_d = (state_d == ST_REPORT);
    end

    // Gather the KxK window at the next position straight from the frame buffer.
    always_comb begin
        win_d   = '0;
        rd_addr = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                rd_addr = AW'((int'(x_d) + i) * IMG_W + int'(y_d) + j);
                win_d[(i*K+j)*8 +: 8] = img_mem[rd_addr];
            end
        end
        imgin_d = win_ld ? win_d : imgin_q;
    end

    assign PIX_READY    = pix_ready;
    assign BUSY         = busy;
    assign START        = start_q;
    assign X            = x_q;
    assign Y            = y_q;
    assign IMGIN        = imgin_q;
    assign RESULT_VALID = result_valid_q;
    assign RESULT       = result_q;

endmodule

// File: doc/cnn_window_feeder.md
CNN_WINDOW_FEEDER -- requirements
Module: cnn_window_feeder

Parameters
REQ-001 The block SHALL have parameter IMG_W, default 28, meaning the square input image edge in pixels.
REQ-002 The block SHALL have parameter K, default 5, meaning the square kernel/window edge in pixels.
REQ-003 The block SHALL have parameter OUT_W, default 24 (IMG_W-K+1), meaning the window positions per axis.

Interface
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock, all logic on its rising edge.
REQ-005 The block SHALL have port nRST, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port PIX_VALID, input, 1 bit: PIX_IN carries a pixel this cycle.
REQ-007 The block SHALL have port PIX_IN, input, 8 bits: unsigned pixel, raster order (row-major, row 0 first).
REQ-008 The block SHALL have port PIX_READY, output, 1 bit: the block accepts a pixel this cycle.
REQ-009 The block SHALL have port START, output, 1 bit: one-cycle pulse opening a frame toward the CNN core.
REQ-010 The block SHALL have port X, output, 5 bits: window row index, 0..OUT_W-1.
REQ-011 The block SHALL have port Y, output, 5 bits: window column index, 0..OUT_W-1.
REQ-012 The block SHALL have port IMGIN, output, 200 bits: the window; byte IMGIN[(i*5+j)*8 +: 8] = pixel(row X+i, col Y+j), i,j in 0..4.
REQ-013 The block SHALL have port CNN_DONE, input, 1 bit: the core's classification-complete pulse.
REQ-014 The block SHALL have port CNN_OUT, input, 4 bits: the core's class index, valid with CNN_DONE.
REQ-015 The block SHALL have port RESULT_VALID, output, 1 bit: one-cycle pulse; RESULT is valid.
REQ-016 The block SHALL have port RESULT, output, 4 bits: the captured class, held until the next capture.
REQ-017 The block SHALL have port BUSY, output, 1 bit: high in every state except LOAD.

Function
REQ-018 The block SHALL implement the states LOAD, KICK, STREAM, WAIT, REPORT, encoded in a registered state variable.
REQ-019 LOAD SHALL drive PIX_READY=1, combinational from the state; a pixel SHALL be accepted only when PIX_VALID and PIX_READY are both 1.
REQ-020 Accepted pixel n (0..IMG_W*IMG_W-1) SHALL be written to image buffer address n, and the pixel counter SHALL increment.
REQ-021 On acceptance of pixel 783, LOAD SHALL go to KICK and clear the counter; PIX_READY SHALL be 0 from the next cycle.
REQ-022 KICK SHALL last exactly one cycle with registered START=1, X=0, Y=0, IMGIN=window(0,0), then go to STREAM.
REQ-023 STREAM SHALL present exactly one new window per cycle, OUT_W*OUT_W=576 cycles, starting at (0,0) on the cycle after KICK.
REQ-024 In STREAM, Y SHALL increment fastest; when Y=23 it SHALL wrap to 0 and X SHALL increment; X, Y and IMGIN SHALL change together, registered.
REQ-025 After the (23,23) cycle, STREAM SHALL go to WAIT; X, Y and IMGIN SHALL hold (23,23) and its window.
REQ-026 WAIT SHALL, on CNN_DONE=1, register RESULT<=CNN_OUT and go to REPORT; no timeout SHALL apply.
REQ-027 REPORT SHALL last exactly one cycle with RESULT_VALID=1, then go to LOAD.
REQ-028 CNN_DONE outside WAIT SHALL be ignored; PIX_VALID outside LOAD SHALL be ignored, with no buffer write and no count change.
REQ-029 START SHALL never be high in any state other than KICK.
REQ-030 Pixel data SHALL be unsigned 8-bit with no arithmetic transformation; the window byte order SHALL be exactly that of REQ-012.

Reset
REQ-031 Asserting nRST=0 SHALL immediately force state=LOAD, pixel counter=0, START=0, X=0, Y=0, IMGIN=0, RESULT=0, RESULT_VALID=0.
REQ-032 While nRST=0 and after release, PIX_READY SHALL equal 1 and BUSY SHALL equal 0, following from the state LOAD.
REQ-033 Image buffer contents SHALL NOT be reset; a reset in the middle of LOAD or STREAM SHALL abandon the frame, and the next frame SHALL restart at pixel 0.

Verification
REQ-034 Bench: load pixel(r,c)=r*28+c mod 256, PIX_VALID always 1 -> 784 acceptances, one START pulse, then 576 windows; window(0,0) byte0=0, byte24=116; window(23,23) byte0=(23*28+23) mod 256=155.
REQ-035 Bench: PIX_VALID toggling 1/0 every cycle -> still exactly 784 accepted; KICK occurs the cycle after the 784th acceptance.
REQ-036 Bench: during STREAM check X,Y per cycle -> sequence (0,0),(0,1)..(0,23),(1,0)..(23,23), with no gaps and no repeats.
REQ-037 Bench: drive CNN_DONE=1, CNN_OUT=7 during STREAM (ignored), then CNN_DONE=1, CNN_OUT=3 in WAIT -> one RESULT_VALID pulse, RESULT=3, back in LOAD with BUSY=0.
REQ-038 Bench: assert nRST=0 when X=10 in STREAM -> all outputs at reset values at once; the following full frame behaves as in REQ-034.
REQ-039 Bench: model the CNN core as the consumer of START/X/Y/IMGIN, run two back-to-back frames -> two RESULT_VALID pulses, each matching the golden-model class.
